// File: rtl/reset_sequencer.sv
// Staged reset release for NUM_STAGES clock domains.
// Each stage is released a fixed delay after the previous one reports ready.
module reset_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int RELEASE_DELAY = 16,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic                  timeout_error,
  output logic [2:0]            active_stage
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    DELAY,
    WAIT_READY,
    DONE,
    FAULT
  } state_t;

  localparam logic [15:0] DLY_LOAD = 16'(RELEASE_DELAY - 1);
  localparam logic [15:0] ACK_LOAD = 16'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  LAST     = 3'(NUM_STAGES - 1);

  state_t                  state;
  logic [15:0]             cnt;
  logic                    ready_act;
  logic [NUM_STAGES-1:0]   act_mask;
  logic                    lock_lost;
  logic                    soft_abort;

  // Select the ready bit and one-hot mask of the stage currently in play.
  always_comb begin
    ready_act = 1'b0;
    act_mask  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (active_stage == 3'(i)) begin
        ready_act   = stage_ready[i];
        act_mask[i] = 1'b1;
      end
    end
  end

  // Abort conditions, loss of lock ranking above a soft request.
  always_comb begin
    lock_lost  = !pll_locked &&
                 (state == DELAY || state == WAIT_READY ||
                  state == DONE);
    soft_abort = soft_reset_req && (state != WAIT_LOCK);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= WAIT_LOCK;
      stage_reset   <= '1;
      all_released  <= 1'b0;
      timeout_error <= 1'b0;
      active_stage  <= 3'd0;
      cnt           <= 16'd0;
    end else if (lock_lost || soft_abort) begin
      state         <= WAIT_LOCK;
      stage_reset   <= '1;
      all_released  <= 1'b0;
      timeout_error <= 1'b0;
      active_stage  <= 3'd0;
      cnt           <= 16'd0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (pll_locked) begin
            state        <= DELAY;
            active_stage <= 3'd0;
            cnt          <= DLY_LOAD;
          end
        end
        DELAY: begin
          if (cnt == 16'd0) begin
            stage_reset <= stage_reset & ~act_mask;
            // A stage already reporting ready when released is
            // acknowledged on its release edge.
            if (ready_act) begin
              if (active_stage == LAST) begin
                state        <= DONE;
                all_released <= 1'b1;
              end else begin
                state        <= DELAY;
                active_stage <= active_stage + 3'd1;
                cnt          <= DLY_LOAD;
              end
            end else begin
              state <= WAIT_READY;
              cnt   <= ACK_LOAD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        WAIT_READY: begin
          if (cnt == 16'd0) begin
            state         <= FAULT;
            stage_reset   <= '1;
            timeout_error <= 1'b1;
          end else if (ready_act) begin
            if (active_stage == LAST) begin
              state        <= DONE;
              all_released <= 1'b1;
            end else begin
              state        <= DELAY;
              active_stage <= active_stage + 3'd1;
              cnt          <= DLY_LOAD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE, FAULT: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of sequenced reset domains; legal range 2..8.
REQ-002 Parameter RELEASE_DELAY, default 16: clock edges from a trigger to the next stage release; legal range 2..65535.
REQ-003 Parameter ACK_TIMEOUT, default 1024: clock edges allowed for a released stage to report ready; legal range 2..65535.
REQ-004 clk_in  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset, already deassert-synchronized to clk_in.
REQ-006 pll_locked  input  1  clock-source lock; synchronous to clk_in.
REQ-007 soft_reset_req  input  1  single-cycle request to restart the sequence.
REQ-008 stage_ready  input  NUM_STAGES  per-stage "out of reset and operational"; level, synchronous.
REQ-009 stage_reset  output  NUM_STAGES  active-high reset per domain; bit 0 is released first.
REQ-010 all_released  output  1  high while state is DONE.
REQ-011 timeout_error  output  1  sticky fault flag.
REQ-012 active_stage  output  3  index of the stage being released or awaited.

Function
REQ-013 The FSM SHALL have the states WAIT_LOCK, DELAY, WAIT_READY, DONE and FAULT, all registered.
REQ-014 In WAIT_LOCK, all stage_reset bits SHALL be 1; on pll_locked=1, the FSM SHALL enter DELAY with active_stage=0 and the counter loaded.
REQ-015 In DELAY, the counter SHALL count RELEASE_DELAY edges; on the final edge, stage_reset[active_stage] SHALL clear and the FSM SHALL enter WAIT_READY with the timeout counter loaded.
REQ-016 Net latency: stage_reset[k] SHALL fall exactly RELEASE_DELAY edges after the edge that sampled the trigger (pll_locked=1 for k=0; stage_ready[k-1]=1 for k>0).
REQ-017 In WAIT_READY, on stage_ready[active_stage]=1: if active_stage=NUM_STAGES-1, the FSM SHALL enter DONE; otherwise it SHALL increment active_stage and enter DELAY.
REQ-018 Released stages SHALL remain released; stage_reset SHALL only be re-asserted all together, never singly.
REQ-019 If ACK_TIMEOUT edges elapse in WAIT_READY without a ready, the FSM SHALL enter FAULT: all stage_reset=1 and timeout_error=1 on that same edge.
REQ-020 FAULT SHALL be exited only by soft_reset_req or reset_in; timeout_error SHALL clear on exit.
REQ-021 pll_locked=0 sampled in DELAY, WAIT_READY or DONE SHALL assert all stage_reset bits on that edge and SHALL enter WAIT_LOCK with active_stage=0.
REQ-022 soft_reset_req=1 in any state other than WAIT_LOCK SHALL assert all stage_reset bits and SHALL enter WAIT_LOCK on that edge.
REQ-023 Event priority SHALL be: reset_in > loss of lock > soft_reset_req > timeout > ready > counter expiry.
REQ-024 stage_ready bits for unreleased stages and for stages other than active_stage SHALL be ignored.
REQ-025 The counters SHALL be 16 bits, SHALL NOT wrap, and SHALL reload on every state entry.
REQ-026 Outputs SHALL be driven directly from flops with no combinational path from input to output.

Reset
REQ-027 reset_in=1 SHALL asynchronously force: state WAIT_LOCK, stage_reset all 1s, all_released=0, timeout_error=0, active_stage=0, counters 0.
REQ-028 reset_in asserted mid-sequence SHALL abort the sequence immediately; after deassertion, the sequence SHALL restart from stage 0.
REQ-029 The FSM SHALL take no transition on the first edge after reset_in deasserts unless pll_locked=1.

Verification (NUM_STAGES=4, RELEASE_DELAY=4, ACK_TIMEOUT=8)
REQ-030 Nominal case: pll_locked rises at edge 10 and each stage_ready follows its release by 2 edges -> stage_reset goes 1111->1110 at edge 14, ->1100 at 20, ->1000 at 26, ->0000 at 32; all_released=1 at edge 34.
REQ-031 Timeout case: stage_ready[1] is held 0 -> 8 edges after stage 1 releases, stage_reset=1111, timeout_error=1, state FAULT; a soft_reset_req pulse then clears timeout_error and the sequence restarts.
REQ-032 Lock-loss case: pll_locked drops in DONE -> stage_reset=1111 on the next edge, all_released=0, active_stage=0; relocking repeats the REQ-030 timing.
REQ-033 Simultaneous events: soft_reset_req and stage_ready[2] both high in WAIT_READY on stage 2 -> soft reset wins: stage_reset=1111, state WAIT_LOCK.
REQ-034 Async reset: reset_in pulses for less than one clock period during DELAY on stage 2 -> stage_reset=1111 immediately with no clock edge; after release, the sequence restarts at stage 0.
REQ-035 Early ready: stage_ready=1111 is held from time 0 -> stages still release strictly one per RELEASE_DELAY, at edges 14, 18, 22 and 26 for lock at edge 10.
